// File: rtl/wordexp.sv
// Montgomery domain-entry converter: R_out = A * 2^(W*L) mod q, q = qH*2^W + 1.
// One doubling-and-conditional-subtract per cycle after a single pre-reduction step.
module wordexp #(
  parameter int unsigned LOGQH = 26,
  parameter int unsigned W     = 34,
  parameter int unsigned L     = 2,
  parameter int unsigned LOGQ  = LOGQH + W,
  parameter int unsigned CNT_W = $clog2(W * L + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  R_out,
  output logic             busy
);

  localparam int unsigned N = W * L;

  // A zero iteration count has no meaningful result.
  if (N == 0) begin : g_n_check
    $error("wordexp: W*L must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LOGQ-1:0]   x;
  logic [LOGQ-1:0]   q_r;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              last;
  logic [LOGQ:0]     t;
  logic              t_ge;
  logic [LOGQ-1:0]   t_red;
  logic [LOGQ-1:0]   x_run;
  logic              x_ge;
  logic [LOGQ-1:0]   x_red;

  // Datapath arithmetic: compare/subtract carried at LOGQ+1 bits so the doubled value never wraps.
  always_comb begin
    t      = {x, 1'b0};
    t_ge   = (t >= {1'b0, q_r});
    t_red  = LOGQ'(t - {1'b0, q_r});
    x_run  = t_ge ? t_red : t[LOGQ-1:0];
    x_ge   = (x >= q_r);
    x_red  = LOGQ'(x - q_r);
    last   = (cnt == CNT_W'(N - 1));
    accept = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN:  if (last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status decode; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: in_ready  = rst;
      S_LOAD: busy      = 1'b1;
      S_RUN:  busy      = 1'b1;
      S_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, pre-reduction, iteration and result latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      q_r   <= '0;
      cnt   <= '0;
      R_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x   <= A;
            q_r <= {qH, W'(1)};
            cnt <= '0;
          end
        end
        S_LOAD: begin
          if (x_ge) x <= x_red;
        end
        S_RUN: begin
          x   <= x_run;
          cnt <= cnt + CNT_W'(1);
          if (last) R_out <= x_run;
        end
        default: ;
      endcase
    end
  end

endmodule
